// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin APB master sharing one APB slave port.
// Optional watchdog on stalled ACCESS phases: define APB_TIMEOUT_EN.
//
// Ports:
//   PCLK, PRESET      clock, async active-high reset
//   req_valid/write   per-requester command valid and direction
//   req_addr/wdata    flattened per-requester address and write data
//   req_ready         one-hot pulse, command accepted (combinational in IDLE)
//   rsp_valid         one-hot pulse, transfer completed
//   rsp_rdata/err     read data (0 for writes) and error flag, with rsp_valid
//   PADDR..PWDATA     registered APB master outputs
//   PRDATA, PREADY    APB slave response
module apb_master_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 8,
  parameter int NREQ      = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_write,
  input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
  input  logic [NREQ*DATAWIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [DATAWIDTH-1:0]      rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDRWIDTH-1:0]      PADDR,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic [DATAWIDTH-1:0]      PWDATA,
  input  logic [DATAWIDTH-1:0]      PRDATA,
  input  logic                      PREADY
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state;
  state_t nxt;

  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        gnt;
  logic [GW-1:0]        gsel;
  logic                 any_req;
  logic                 grant;
  logic                 done;
  logic                 tmo;
  logic [NREQ-1:0]      gsel_oh;
  logic [NREQ-1:0]      gnt_oh;
  logic [ADDRWIDTH-1:0] addr_sel;
  logic [DATAWIDTH-1:0] wdata_sel;
  logic                 write_sel;

  // Round-robin search: first valid requester after last_grant,
  // wrapping modulo NREQ, so the previous winner is tried last.
  always_comb begin
    int k;
    k       = 0;
    any_req = 1'b0;
    gsel    = last_grant;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(last_grant) + i) % NREQ;
      if (!any_req && req_valid[k]) begin
        any_req = 1'b1;
        gsel    = GW'(k);
      end
    end
  end

  always_comb begin
    addr_sel  = req_addr[int'(gsel)*ADDRWIDTH +: ADDRWIDTH];
    wdata_sel = req_wdata[int'(gsel)*DATAWIDTH +: DATAWIDTH];
    write_sel = req_write[gsel];
  end

  // state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          nxt = SETUP;
        end
      end
      SETUP: begin
        nxt = ACCESS;
      end
      ACCESS: begin
        if (PREADY || tmo) begin
          nxt = IDLE;
        end
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  // output decode
  always_comb begin
    // ready is combinational; keep it quiet while reset is held
    grant   = (state == IDLE) && any_req && !PRESET;
    done    = (state == ACCESS) && PREADY;
    gsel_oh = '0;
    gsel_oh[gsel] = 1'b1;
    gnt_oh  = '0;
    gnt_oh[gnt] = 1'b1;
    req_ready = grant ? gsel_oh : '0;
  end

  // APB and response registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR      <= '0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      gnt        <= '0;
      last_grant <= GW'(NREQ - 1);
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
    end else begin
      PSEL      <= (nxt != IDLE);
      PENABLE   <= (nxt == ACCESS);
      rsp_valid <= (done || tmo) ? gnt_oh : '0;
      if (grant) begin
        PADDR      <= addr_sel;
        PWDATA     <= wdata_sel;
        PWRITE     <= write_sel;
        gnt        <= gsel;
        last_grant <= gsel;
      end
      if (done) begin
        rsp_rdata <= PWRITE ? '0 : PRDATA;
      end else if (tmo) begin
        rsp_rdata <= '0;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // cnt counts stalled ACCESS cycles; abort on the TIMEOUT-th one
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt <= '0;
    end else if (state == SETUP) begin
      cnt <= '0;
    end else if (state == ACCESS && !PREADY) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tmo = (state == ACCESS) && !PREADY &&
               (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= tmo;
    end
  end
`else
  // no watchdog: ACCESS waits on PREADY indefinitely
  assign tmo     = (TIMEOUT < 0);
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed checks of the round-robin APB master.
// Drives/samples 1ns after each rising edge; slave is a simple memory.
module tb_apb_master_arbiter;

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] mem [256];

  apb_master_arbiter #(
    .DATAWIDTH(32),
    .ADDRWIDTH(8),
    .NREQ(2),
    .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PADDR(PADDR),
    .PWRITE(PWRITE),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  assign PRDATA = mem[PADDR];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY && PWRITE) begin
      mem[PADDR] <= PWDATA;
    end
  end

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset;
    PRESET = 1'b1;
    req_valid = 2'b11;
    tick();
    tick();
    total_cnt++;
    if (req_ready !== 2'b00) $display("FAIL rst_ready got %b want 00", req_ready);
    else pass_cnt++;
    total_cnt++;
    if ({PSEL, PENABLE} !== 2'b00) $display("FAIL rst_psel got %b want 00", {PSEL, PENABLE});
    else pass_cnt++;
    total_cnt++;
    if (PADDR !== 8'h00 || PWDATA !== 32'h0 || PWRITE !== 1'b0)
      $display("FAIL rst_apb got %h/%h/%b want 0", PADDR, PWDATA, PWRITE);
    else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== 2'b00 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      $display("FAIL rst_rsp got %b/%h/%b want 0", rsp_valid, rsp_rdata, rsp_err);
    else pass_cnt++;
    req_valid = 2'b00;
    PRESET = 1'b0;
    tick();
  endtask

  task automatic test_single_write;
    req_addr[7:0] = 8'h10;
    req_wdata[31:0] = 32'hA5A5A5A5;
    req_write = 2'b01;
    req_valid = 2'b01;
    PREADY = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL wr_ready got %b want 01", req_ready);
    else pass_cnt++;
    tick();
    req_valid = 2'b00;
    total_cnt++;
    if ({PSEL, PENABLE} !== 2'b10) $display("FAIL wr_setup got %b want 10", {PSEL, PENABLE});
    else pass_cnt++;
    total_cnt++;
    if (PADDR !== 8'h10 || PWRITE !== 1'b1 || PWDATA !== 32'hA5A5A5A5)
      $display("FAIL wr_apb got %h/%b/%h want 10/1/a5a5a5a5", PADDR, PWRITE, PWDATA);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({PSEL, PENABLE} !== 2'b11 || rsp_valid !== 2'b00)
      $display("FAIL wr_access got %b/%b want 11/00", {PSEL, PENABLE}, rsp_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b0)
      $display("FAIL wr_rsp got %b/%b want 01/0", rsp_valid, rsp_err);
    else pass_cnt++;
    total_cnt++;
    if (rsp_rdata !== 32'h0 || PSEL !== 1'b0)
      $display("FAIL wr_rdata got %h/%b want 0/0", rsp_rdata, PSEL);
    else pass_cnt++;
    total_cnt++;
    if (mem[8'h10] !== 32'hA5A5A5A5) $display("FAIL wr_mem got %h want a5a5a5a5", mem[8'h10]);
    else pass_cnt++;
  endtask

  task automatic test_read_back;
    req_write = 2'b00;
    req_valid = 2'b01;
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL rd_ready got %b want 01", req_ready);
    else pass_cnt++;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hA5A5A5A5)
      $display("FAIL rd_rsp got %b/%h want 01/a5a5a5a5", rsp_valid, rsp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_oh;
    logic [1:0] prev_oh;
    logic [7:0] exp_addr;
    bit         got;
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    req_addr = {8'h02, 8'h01};
    req_write = 2'b00;
    req_valid = 2'b11;
    prev_oh = 2'b00;
    #1;
    for (int t = 0; t < 4; t++) begin
      exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (t % 2 == 0) ? 8'h01 : 8'h02;
      got = 1'b0;
      for (int c = 0; c < 10; c++) begin
        if (req_ready !== 2'b00) begin
          got = 1'b1;
          break;
        end
        tick();
      end
      total_cnt++;
      if (!got) $display("FAIL rr_timeout transfer %0d got no grant want %b", t, exp_oh);
      else if (req_ready !== exp_oh) $display("FAIL rr_grant%0d got %b want %b", t, req_ready, exp_oh);
      else pass_cnt++;
      if (t > 0) begin
        total_cnt++;
        if (rsp_valid !== prev_oh) $display("FAIL rr_rsp%0d got %b want %b", t, rsp_valid, prev_oh);
        else pass_cnt++;
      end
      tick();
      if (t == 3) req_valid = 2'b00;
      total_cnt++;
      if (PADDR !== exp_addr || PSEL !== 1'b1)
        $display("FAIL rr_paddr%0d got %h/%b want %h/1", t, PADDR, PSEL, exp_addr);
      else pass_cnt++;
      prev_oh = exp_oh;
    end
    tick();
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b10) $display("FAIL rr_last_rsp got %b want 10", rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_wait_states;
    req_addr[15:8] = 8'h33;
    req_wdata[63:32] = 32'h12345678;
    req_write = 2'b10;
    req_valid = 2'b10;
    PREADY = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 2'b10) $display("FAIL ws_ready got %b want 10", req_ready);
    else pass_cnt++;
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if ({PSEL, PENABLE} !== 2'b11 || PADDR !== 8'h33 || rsp_valid !== 2'b00)
        $display("FAIL ws_hold%0d got %b/%h/%b want 11/33/00", i, {PSEL, PENABLE}, PADDR, rsp_valid);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if ({PSEL, PENABLE} !== 2'b11 || rsp_valid !== 2'b00)
      $display("FAIL ws_hold5 got %b/%b want 11/00", {PSEL, PENABLE}, rsp_valid);
    else pass_cnt++;
    PREADY = 1'b1;
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b10 || rsp_err !== 1'b0 || PSEL !== 1'b0)
      $display("FAIL ws_rsp got %b/%b/%b want 10/0/0", rsp_valid, rsp_err, PSEL);
    else pass_cnt++;
    total_cnt++;
    if (mem[8'h33] !== 32'h12345678) $display("FAIL ws_mem got %h want 12345678", mem[8'h33]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int stray;
    req_addr[7:0] = 8'h10;
    req_write = 2'b00;
    req_valid = 2'b01;
    PREADY = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL rm_ready got %b want 01", req_ready);
    else pass_cnt++;
    tick();
    req_valid = 2'b00;
    tick();
    total_cnt++;
    if (PENABLE !== 1'b1) $display("FAIL rm_access got %b want 1", PENABLE);
    else pass_cnt++;
    PRESET = 1'b1;
    #1;
    total_cnt++;
    if ({PSEL, PENABLE} !== 2'b00) $display("FAIL rm_async got %b want 00", {PSEL, PENABLE});
    else pass_cnt++;
    tick();
    PRESET = 1'b0;
    PREADY = 1'b1;
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid !== 2'b00) stray++;
    end
    total_cnt++;
    if (stray != 0) $display("FAIL rm_stray_rsp got %0d pulses want 0", stray);
    else pass_cnt++;
    req_addr = {8'h02, 8'h10};
    req_valid = 2'b11;
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL rm_regrant got %b want 01", req_ready);
    else pass_cnt++;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hA5A5A5A5)
      $display("FAIL rm_rsp got %b/%h want 01/a5a5a5a5", rsp_valid, rsp_rdata);
    else pass_cnt++;
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout;
    req_addr[15:8] = 8'h02;
    req_write = 2'b00;
    req_valid = 2'b10;
    PREADY = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 2'b10) $display("FAIL to_ready got %b want 10", req_ready);
    else pass_cnt++;
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 16; i++) begin
      tick();
      total_cnt++;
      if ({PSEL, PENABLE} !== 2'b11) $display("FAIL to_hold%0d got %b want 11", i, {PSEL, PENABLE});
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (PSEL !== 1'b0 || rsp_valid !== 2'b10)
      $display("FAIL to_abort got %b/%b want 0/10", PSEL, rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
      $display("FAIL to_err got %b/%h want 1/0", rsp_err, rsp_rdata);
    else pass_cnt++;
    PREADY = 1'b1;
    tick();
  endtask
`endif

  initial begin
    PRESET = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    PREADY = 1'b1;
    test_reset();
    test_single_write();
    test_read_back();
    test_round_robin();
    test_wait_states();
    test_reset_mid();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Round-robin APB master that shares the single APB_Slave register port between NREQ requesters (softmax control engine, host loader, etc.).
- Each requester issues single read/write commands; the block serialises them into APB SETUP/ACCESS transfers and returns read data plus a completion strobe to the winning requester.
- Sits between the requester fabric and the APB_Slave instance.

Parameters:
- DATAWIDTH, 32, APB data width (PWDATA/PRDATA).
- ADDRWIDTH, 8, APB address width (PADDR).
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY (used only with APB_TIMEOUT_EN).

Ports:
- PCLK  in  1  single clock, rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester command valid; held until req_ready.
- req_write  in  NREQ  1=write, 0=read.
- req_addr  in  NREQ*ADDRWIDTH  flattened addresses; requester k at [k*ADDRWIDTH +: ADDRWIDTH].
- req_wdata  in  NREQ*DATAWIDTH  flattened write data.
- req_ready  out  NREQ  one-hot, 1-cycle pulse: command accepted.
- rsp_valid  out  NREQ  one-hot, 1-cycle pulse: transfer completed.
- rsp_rdata  out  DATAWIDTH  read data, valid with rsp_valid (0 for writes).
- rsp_err  out  1  error flag, valid with rsp_valid.
- PADDR  out  ADDRWIDTH  APB address.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWDATA  out  DATAWIDTH  APB write data.
- PRDATA  in  DATAWIDTH  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; state=IDLE; round-robin pointer last_grant=NREQ-1, so requester 0 has top priority first.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - if any req_valid, grant the first valid requester searching from last_grant+1 modulo NREQ.
  - Pulse req_ready[g] that cycle; latch addr/wdata/write and g; last_grant<=g; go to SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from the latched command; next cycle -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1, same address/data; hold while PREADY=0.
- On PREADY=1 in ACCESS:
  - rsp_rdata<=PRDATA for reads, 0 for writes.
  - rsp_valid[g] pulses the following cycle; rsp_err=0.
  - Go to IDLE with PSEL=PENABLE=0.
- Best-case latency: req_ready at cycle 0, SETUP cycle 1, ACCESS cycle 2, rsp_valid cycle 3.
  - Next grant is possible in the same cycle rsp_valid pulses (IDLE).
- APB outputs are registered and stable for the whole transfer.
- PWDATA holds its last value when idle; PADDR likewise.
- req_valid deasserted before req_ready: the command is dropped, with no side effects.
- Simultaneous requests are served strictly round-robin; no requester is starved for more than NREQ-1 transfers.
- PRESET asserted mid-transfer: PSEL/PENABLE drop immediately (async), no rsp_valid is issued for the aborted command, pointer is reset.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT+1)-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - On reaching TIMEOUT: abort to IDLE, drop PSEL/PENABLE, pulse rsp_valid[g] with rsp_err=1 and rsp_rdata=0.
- Undefined: no counter; ACCESS waits indefinitely; rsp_err tied 0.

Test Plan:
- Single write, req0 addr 0x10 data 0xA5A5A5A5, PREADY=1 -> SETUP then ACCESS with PADDR=0x10 and PWRITE=1; rsp_valid[0] 3 cycles after req_ready[0]; rsp_err=0.
- Read back addr 0x10 from the slave model -> rsp_rdata=0xA5A5A5A5 on rsp_valid[0].
- req0 and req1 both valid continuously (addrs 0x01, 0x02) for 4 transfers -> grant order 0,1,0,1; PADDR sequence 01,02,01,02.
- PREADY held low 5 ACCESS cycles -> PSEL/PENABLE/PADDR stable all 5 cycles; rsp_valid one cycle after PREADY rises.
- PRESET pulsed during ACCESS -> PSEL=PENABLE=0 immediately; no rsp_valid; the next request after release is granted to req0.
- With APB_TIMEOUT_EN and TIMEOUT=16, PREADY stuck low -> abort after 16 ACCESS cycles; rsp_valid with rsp_err=1 and rsp_rdata=0.
